// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sizes, coefficient set and FSM encoding for fir_decim
package fir_pkg;
  localparam int NTAPS  = 27;
  localparam int PW     = $clog2(NTAPS);
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 40;
  localparam int CW     = 16;

  typedef logic [1:0] fir_state_t;
  localparam fir_state_t ST_IDLE = 2'd0;
  localparam fir_state_t ST_MAC  = 2'd1;
  localparam fir_state_t ST_OUT  = 2'd2;

  // Symmetric Q15 low-pass: only taps 0..13 are stored, the rest mirror around tap 13
  function automatic logic signed [CW-1:0] coef(input logic [PW-1:0] k);
    logic [PW-1:0] m;
    m = (k > PW'(13)) ? PW'(26) - k : k;
    case (m)
      5'd0:    coef = -16'sd255;
      5'd1:    coef = -16'sd260;
      5'd2:    coef = -16'sd312;
      5'd3:    coef = -16'sd288;
      5'd4:    coef = -16'sd144;
      5'd5:    coef = 16'sd153;
      5'd6:    coef = 16'sd616;
      5'd7:    coef = 16'sd1233;
      5'd8:    coef = 16'sd1963;
      5'd9:    coef = 16'sd2739;
      5'd10:   coef = 16'sd3474;
      5'd11:   coef = 16'sd4081;
      5'd12:   coef = 16'sd4481;
      default: coef = 16'sd4620;
    endcase
  endfunction
endpackage

// File: rtl/fir_decim_if.sv
// rtl/fir_decim_if.sv - input and output sample handshakes of fir_decim
interface fir_decim_if import fir_pkg::*; #(parameter int DW = DW_DEF);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_sample_ring.sv
// rtl/fir_sample_ring.sv - NTAPS-deep sample history with newest-relative read
module fir_sample_ring import fir_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 wr_en,
  input  logic signed [DW-1:0] wr_data,
  input  logic [PW-1:0]        rd_k,
  output logic signed [DW-1:0] rd_data
);
  localparam int SW = PW + 1;

  logic signed [DW-1:0] ring [NTAPS];
  logic [PW-1:0]        wr_ptr;
  logic [SW-1:0]        rd_sum;
  logic [PW-1:0]        rd_idx;

  // Newest sample sits just behind wr_ptr; adding NTAPS-1 keeps the sum non-negative
  always_comb begin
    rd_sum = {1'b0, wr_ptr} + SW'(NTAPS - 1) - {1'b0, rd_k};
    rd_idx = (rd_sum >= SW'(NTAPS)) ? PW'(rd_sum - SW'(NTAPS)) : rd_sum[PW-1:0];
  end

  assign rd_data = ring[rd_idx];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < NTAPS; i++) ring[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      ring[wr_ptr] <= wr_data;
      wr_ptr       <= (wr_ptr == PW'(NTAPS - 1)) ? '0 : wr_ptr + PW'(1);
    end
  end
endmodule

// File: rtl/fir_decim.sv
// rtl/fir_decim.sv - decimating 27-tap FIR with one time-multiplexed MAC
module fir_decim import fir_pkg::*; #(
  parameter int DECIM = 4,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int SHIFT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  fir_decim_if.slave bus
);
  localparam logic signed [AW-1:0] RND  = {{(AW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAX_OUT = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_OUT = {1'b1, {(DW-1){1'b0}}};

  fir_state_t           state;
  logic [3:0]           phase;
  logic [PW-1:0]        k;
  logic [PW-1:0]        rd_k;
  logic                 accept;
  logic signed [DW-1:0] x_rd;
  logic signed [AW-1:0] c_ext, x_ext, prod, prod_q, acc;
  logic signed [AW-1:0] acc_sum, rnd, shifted;
  logic                 sat_hi, sat_lo;
  logic signed [DW-1:0] out_data_q;
  logic                 out_sat_q;

  assign accept = bus.in_valid && (state == ST_IDLE);
  assign rd_k   = (k < PW'(NTAPS)) ? k : '0;

  fir_sample_ring #(.DW(DW)) u_ring (
    .clk     (clk),
    .clr_n   (rst_n),
    .wr_en   (accept),
    .wr_data (bus.in_data),
    .rd_k    (rd_k),
    .rd_data (x_rd)
  );

  // Product is registered, so the accumulator trails tap k by one cycle and the
  // final tap is folded in combinationally when the result is captured.
  always_comb begin
    c_ext   = AW'(coef(rd_k));
    x_ext   = AW'(x_rd);
    prod    = c_ext * x_ext;
    acc_sum = acc + prod_q;
    rnd     = acc_sum + RND;
    shifted = rnd >>> SHIFT;
    sat_hi  = shifted > MAXV;
    sat_lo  = shifted < MINV;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      k          <= '0;
      acc        <= '0;
      prod_q     <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (phase == 4'(DECIM - 1)) begin
              phase <= '0;
              acc   <= '0;
              k     <= '0;
              state <= ST_MAC;
            end else begin
              phase <= phase + 4'd1;
            end
          end
        end
        ST_MAC: begin
          if (k != '0) acc <= acc_sum;
          if (k == PW'(NTAPS)) begin
            out_data_q <= sat_hi ? MAX_OUT : (sat_lo ? MIN_OUT : shifted[DW-1:0]);
            out_sat_q  <= sat_hi || sat_lo;
            state      <= ST_OUT;
          end else begin
            prod_q <= prod;
            k      <= k + PW'(1);
          end
        end
        ST_OUT: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_fir_decim.sv
// tb/tb_fir_decim.sv - scoreboard bench for fir_decim at DECIM=1 and DECIM=4
module tb_fir_decim;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_decim_if #(.DW(16)) b1 ();
  fir_decim_if #(.DW(16)) b4 ();

  fir_decim #(.DECIM(1), .DW(16), .AW(40), .SHIFT(15)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  fir_decim #(.DECIM(4), .DW(16), .AW(40), .SHIFT(15)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  localparam int H [27] = '{-255, -260, -312, -288, -144, 153, 616, 1233, 1963, 2739, 3474,
                            4081, 4481, 4620, 4481, 4081, 3474, 2739, 1963, 1233, 616, 153,
                            -144, -288, -312, -260, -255};

  int checks = 0;
  int failures = 0;
  logic [16:0] q1[$];
  logic [16:0] q4[$];
  longint hist[$];
  int acc_cnt = 0;
  int out4_cnt = 0;
  logic signed [15:0] last4_data = '0;
  logic last4_sat = 1'b0;

  function automatic void check(string name, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endfunction

  function automatic void fail_bound(string name);
    checks++;
    failures++;
    $display("FAIL %s got=timeout expected=event", name);
  endfunction

  // Direct convolution over everything accepted since reset
  function automatic logic [16:0] golden();
    longint a = 0;
    longint y;
    int n = hist.size();
    for (int k = 0; k < 27; k++)
      if (n - 1 - k >= 0) a += longint'(H[k]) * hist[n-1-k];
    y = (a + 16384) >>> 15;
    if (y > 32767) return {1'b1, 16'h7fff};
    if (y < -32768) return {1'b1, 16'h8000};
    return {1'b0, y[15:0]};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send1(input logic signed [15:0] x);
    int t = 0;
    b1.in_valid = 1'b1;
    b1.in_data  = 16'sh5a5a;
    while (!b1.in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) fail_bound("u1_in_ready_wait");
    b1.in_data = x;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    b1.in_data  = 16'sh1234;
  endtask

  task automatic send4(input logic signed [15:0] x);
    int t = 0;
    b4.in_valid = 1'b1;
    b4.in_data  = 16'sh5a5a;
    while (!b4.in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) fail_bound("u4_in_ready_wait");
    b4.in_data = x;
    @(posedge clk);
    hist.push_back(longint'(x));
    acc_cnt++;
    if (acc_cnt % 4 == 0) q4.push_back(golden());
    #1;
    b4.in_valid = 1'b0;
    b4.in_data  = 16'sh1234;
  endtask

  task automatic send4_gap(input logic signed [15:0] x);
    send4(x);
    idle($urandom_range(0, 2));
  endtask

  task automatic drain(input int which);
    int t = 0;
    while (((which == 1) ? q1.size() : q4.size()) != 0 && t < 3000) begin idle(1); t++; end
    if (t >= 3000) fail_bound((which == 1) ? "u1_drain" : "u4_drain");
  endtask

  always @(negedge clk) begin : mon1
    logic [16:0] e;
    if (rst_n && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        fail_bound("u1_unexpected_output");
      end else begin
        e = q1.pop_front();
        check("u1_data", b1.out_data, $signed(e[15:0]));
        check("u1_sat", b1.out_sat, e[16]);
      end
    end
  end

  always @(negedge clk) begin : mon4
    logic [16:0] e;
    if (rst_n && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        fail_bound("u4_unexpected_output");
      end else begin
        e = q4.pop_front();
        check("u4_data", b4.out_data, $signed(e[15:0]));
        check("u4_sat", b4.out_sat, e[16]);
      end
      last4_data = b4.out_data;
      last4_sat  = b4.out_sat;
      out4_cnt++;
    end
  end

  initial begin
    int base;
    int bad;
    int t;
    logic signed [15:0] held;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b1;
    rst_n = 1'b0;
    idle(2);
    check("rst_in_ready", b4.in_ready, 1);
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_out_data", b4.out_data, 0);
    check("rst_out_sat", b4.out_sat, 0);
    check("rst_u1_in_ready", b1.in_ready, 1);
    rst_n = 1'b1;

    // Impulse through the non-decimating instance reproduces the coefficients
    for (int i = 0; i < 32; i++) begin
      if (i < 27) q1.push_back({1'b0, 16'(H[i])});
      else        q1.push_back(17'd0);
      send1((i == 0) ? 16'sd32767 : 16'sd0);
    end
    drain(1);

    base = out4_cnt;
    for (int i = 0; i < 40; i++) send4_gap(16'sd1000);
    drain(4);
    check("dc_count", out4_cnt - base, 10);
    check("dc_value", last4_data, 1208);
    check("dc_sat", last4_sat, 0);

    // Completing accept at edge T: out_valid low after T+27, high after T+28
    for (int i = 0; i < 4; i++) send4(16'sd500);
    repeat (27) @(posedge clk);
    #1;
    check("lat_t27_valid", b4.out_valid, 0);
    @(posedge clk); #1;
    check("lat_t28_valid", b4.out_valid, 1);
    drain(4);

    for (int i = 0; i < 40; i++) send4_gap(16'sd32767);
    drain(4);
    check("sat_pos_value", last4_data, 32767);
    check("sat_pos_flag", last4_sat, 1);
    for (int i = 0; i < 40; i++) send4_gap(-16'sd32768);
    drain(4);
    check("sat_neg_value", last4_data, -32768);
    check("sat_neg_flag", last4_sat, 1);

    b4.out_ready = 1'b0;
    send4(16'sd100); send4(-16'sd200); send4(16'sd300); send4(-16'sd400);
    t = 0;
    while (!b4.out_valid && t < 100) begin idle(1); t++; end
    if (t >= 100) fail_bound("bp_wait_valid");
    held = b4.out_data;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      idle(1);
      if (b4.out_data !== held || b4.in_ready !== 1'b0 || b4.out_valid !== 1'b1) bad++;
    end
    check("bp_hold_violations", bad, 0);
    b4.out_ready = 1'b1;
    idle(1);
    check("bp_release_valid", b4.out_valid, 0);
    check("bp_release_in_ready", b4.in_ready, 1);
    send4_gap(16'sd1111); send4_gap(-16'sd2222); send4_gap(16'sd3333); send4_gap(16'sd4444);
    drain(4);

    // Reset lands on the tenth MAC edge; the in-flight result must vanish
    for (int i = 0; i < 4; i++) send4(16'sd20000);
    idle(9);
    rst_n = 1'b0;
    q4.delete();
    hist.delete();
    acc_cnt = 0;
    idle(1);
    check("mid_rst_out_valid", b4.out_valid, 0);
    check("mid_rst_in_ready", b4.in_ready, 1);
    check("mid_rst_out_data", b4.out_data, 0);
    rst_n = 1'b1;
    base = out4_cnt;
    for (int i = 0; i < 32; i++) send4_gap((i == 0) ? 16'sd32767 : 16'sd0);
    drain(4);
    check("post_rst_count", out4_cnt - base, 8);
    check("post_rst_last", last4_data, 0);

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
